// File: rtl/mcc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
// Covers FSM state codes, opcode values and datapath mux-select encodings.
package mcc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_SLT   = 3'b001;
    localparam logic [2:0] OP_J     = 3'b010;
    localparam logic [2:0] OP_JAL   = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_ADDI  = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT       = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    // Loads and stores share the address-calculation EXEC step and go through MEM.
    function automatic logic isMemOp(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mcc_out_decode.sv
// Moore output decoder for the multi-cycle controller: maps the registered
// state and latched opcode (plus hold / memory-ready) to datapath controls.
module mcc_out_decode
    import mcc_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] op_i,
    input  logic       hold_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] pc_src_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       instr_done_o
);

    // Per-state control word; hold suppresses every write and the done strobe last.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        reg_write_o     = 1'b0;
        pc_src_o        = PC_SRC_ALU;
        reg_dst_o       = REG_DST_RT;
        mem_to_reg_o    = MEM_TO_REG_ALU;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALU_ADD;
        instr_done_o    = 1'b0;

        case (state_i)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALU_ADD;
                pc_src_o    = PC_SRC_ALU;
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SHL2;
                alu_op_o    = ALU_ADD;
            end
            ST_EXEC: begin
                case (op_i)
                    OP_RTYPE, OP_SLT: begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = SRCB_RT;
                        alu_op_o    = (op_i == OP_SLT) ? ALU_SLT : ALU_FUNCT;
                    end
                    OP_J: begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = PC_SRC_JUMP;
                        instr_done_o = 1'b1;
                    end
                    OP_JAL: begin
                        pc_write_o   = 1'b1;
                        pc_src_o     = PC_SRC_JUMP;
                        reg_write_o  = 1'b1;
                        reg_dst_o    = REG_DST_R31;
                        mem_to_reg_o = MEM_TO_REG_PC;
                        instr_done_o = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_src_a_o     = 1'b1;
                        alu_op_o        = ALU_SUB;
                        pc_write_cond_o = 1'b1;
                        pc_src_o        = PC_SRC_BRANCH;
                        instr_done_o    = 1'b1;
                    end
                    default: begin
                        alu_src_a_o = 1'b1;
                        alu_src_b_o = SRCB_IMM;
                        alu_op_o    = ALU_ADD;
                    end
                endcase
            end
            ST_MEM: begin
                if (op_i == OP_LW) begin
                    mem_read_o = 1'b1;
                end else if (op_i == OP_SW) begin
                    mem_write_o  = mem_ready_i;
                    instr_done_o = mem_ready_i;
                end
            end
            ST_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                if (op_i == OP_RTYPE || op_i == OP_SLT) begin
                    reg_dst_o = REG_DST_RD;
                end else if (op_i == OP_LW) begin
                    mem_to_reg_o = MEM_TO_REG_MEM;
                end
            end
            default: begin
            end
        endcase

        if (hold_i) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            ir_write_o      = 1'b0;
            reg_write_o     = 1'b0;
            mem_write_o     = 1'b0;
            instr_done_o    = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencing controller for the 3-bit-opcode MIPS datapath.
// Holds the state register, latched opcode and retired-instruction counter.
// Optional feature macro MCC_MEM_WAIT_EN adds the mem_ready port so FETCH and
// MEM wait for memory completion; without it memory is single-cycle.
module multicycle_ctrl_fsm
    import mcc_pkg::*;
#(
    parameter int INSTR_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             opcode,
    input  logic                   hold,
`ifdef MCC_MEM_WAIT_EN
    input  logic                   mem_ready,
`endif
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic                   ir_write,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic [1:0]             pc_src,
    output logic [1:0]             reg_dst,
    output logic [1:0]             mem_to_reg,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   instr_done,
    output logic [2:0]             state,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [INSTR_CNT_W-1:0] count_q, count_d;
    logic                   memReady;

`ifdef MCC_MEM_WAIT_EN
    assign memReady = mem_ready;
`else
    assign memReady = 1'b1;
`endif

    mcc_out_decode u_out_decode (
        .state_i         (state_q),
        .op_i            (op_q),
        .hold_i          (hold),
        .mem_ready_i     (memReady),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .ir_write_o      (ir_write),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .reg_write_o     (reg_write),
        .pc_src_o        (pc_src),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .instr_done_o    (instr_done)
    );

    // Next state, opcode latch and counter update; hold freezes all three.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        if (!hold) begin
            case (state_q)
                ST_IDLE:   state_d = ST_FETCH;
                ST_FETCH:  state_d = memReady ? ST_DECODE : ST_FETCH;
                ST_DECODE: state_d = ST_EXEC;
                ST_EXEC: begin
                    if (op_q == OP_J || op_q == OP_JAL || op_q == OP_BEQ) begin
                        state_d = ST_FETCH;
                    end else if (isMemOp(op_q)) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    if (memReady) begin
                        state_d = (op_q == OP_LW) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:     state_d = ST_FETCH;
                default:   state_d = ST_IDLE;
            endcase
            if (state_q == ST_DECODE) begin
                op_d = opcode;
            end
            if (instr_done) begin
                count_d = count_q + INSTR_CNT_W'(1);
            end
        end
    end

    // State, opcode and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RTYPE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed instruction sequences
// followed by random opcodes, holds (and memory waits with MCC_MEM_WAIT_EN).
module tb_multicycle_ctrl_fsm;

    localparam int CNT_W   = 2;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             hold;
    logic             memReady;
    logic [2:0]       opcode;
    logic             pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]       pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic             alu_src_a, instr_done;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic [17:0]      obsWord;

    int total = 0;
    int bad = 0;
    int modelCount = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.INSTR_CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .hold          (hold),
`ifdef MCC_MEM_WAIT_EN
        .mem_ready     (memReady),
`endif
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .pc_src        (pc_src),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .state         (state),
        .instr_count   (instr_count)
    );

    assign obsWord = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
                      pc_src, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Number of cycles an instruction occupies with no waits or holds.
    function automatic int pathLen(input logic [2:0] op);
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 3;
        if (op == 3'd4) return 5;
        return 4;
    endfunction

    // Which state (by code) the idx-th cycle of an instruction should be in.
    function automatic int stageAt(input logic [2:0] op, input int idx);
        if (idx < 3) return idx + 1;
        if (idx == 3) return (op == 3'd4 || op == 3'd5) ? 4 : 5;
        return 5;
    endfunction

    // Expected control word for a cycle, written straight from the control tables.
    function automatic logic [17:0] expWord(input int st, input logic [2:0] op,
                                            input bit h, input bit rdy);
        logic pcw = 0, pcc = 0, irw = 0, mr = 0, mw = 0, rw = 0, a = 0, dn = 0;
        logic [1:0] ps = 0, rd = 0, mtr = 0, b = 0, alu = 0;
        case (st)
            1: begin mr = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            2: b = 2'b11;
            3: case (op)
                   3'd0: begin a = 1; alu = 2'b10; end
                   3'd1: begin a = 1; alu = 2'b11; end
                   3'd2: begin pcw = 1; ps = 2'b10; dn = 1; end
                   3'd3: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; dn = 1; end
                   3'd6: begin a = 1; alu = 2'b01; pcc = 1; ps = 2'b01; dn = 1; end
                   default: begin a = 1; b = 2'b10; end
               endcase
            4: if (op == 3'd4) mr = 1; else begin mw = rdy; dn = rdy; end
            5: begin
                   rw = 1; dn = 1;
                   if (op == 3'd0 || op == 3'd1) rd = 2'b01;
                   if (op == 3'd4) mtr = 2'b01;
               end
            default: ;
        endcase
        if (h) begin
            pcw = 0; pcc = 0; irw = 0; rw = 0; mw = 0; dn = 0;
        end
        return {pcw, pcc, irw, mr, mw, rw, ps, rd, mtr, a, b, alu, dn};
    endfunction

    // Hold reset for n edges, verify the idle state, then release into FETCH.
    task automatic doReset(input int n, input bit withHold);
        rst = 1'b1;
        hold = withHold;
        memReady = 1'b1;
        repeat (n) tick();
        checkVal("rst_state", 32'(state), 32'd0);
        checkVal("rst_ctrl", 32'(obsWord), 32'd0);
        checkVal("rst_count", 32'(instr_count), 32'd0);
        modelCount = 0;
        rst = 1'b0;
        hold = 1'b0;
        #1;
        checkVal("idle_after_release", 32'(state), 32'd0);
        tick();
    endtask

    // Walk one instruction cycle by cycle, checking state, controls and count.
    task automatic applyStimulus(input logic [2:0] op, input int holdStage, input int holdN,
                                 input bit randHold, input int abortStage);
        int st;
        int held;
        int waited;
        bit adv;
        for (int i = 0; i < pathLen(op); i++) begin
            st = stageAt(op, i);
            held = 0;
            waited = 0;
            if (st == abortStage) begin
                doReset(1, 1'b0);
                return;
            end
            do begin
                opcode = (st == 2) ? op : 3'($urandom);
                if (st == holdStage && held < holdN) hold = 1'b1;
                else if (randHold && held < 2 && $urandom_range(0, 3) == 0) hold = 1'b1;
                else hold = 1'b0;
`ifdef MCC_MEM_WAIT_EN
                memReady = (waited >= 3) || ($urandom_range(0, 2) != 0);
`else
                memReady = 1'b1;
`endif
                #1;
                checkVal("state", 32'(state), 32'(st));
                checkVal("ctrl", 32'(obsWord), 32'(expWord(st, op, hold, memReady)));
                checkVal("count", 32'(instr_count), 32'(modelCount));
                adv = !hold && (memReady || (st != 1 && st != 4));
                if (hold) held++; else waited++;
                if (adv && i == pathLen(op) - 1) modelCount = (modelCount + 1) % CNT_MOD;
                tick();
            end while (!adv);
        end
        hold = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        opcode = 3'd0;
        memReady = 1'b1;

        doReset(2, 1'b0);

        applyStimulus(3'd4, -1, 0, 1'b0, -1);
        checkVal("lw_count", 32'(instr_count), 32'd1);

        applyStimulus(3'd7, -1, 0, 1'b0, -1);
        applyStimulus(3'd6, -1, 0, 1'b0, -1);
        applyStimulus(3'd3, -1, 0, 1'b0, -1);
        applyStimulus(3'd5, -1, 0, 1'b0, -1);
        checkVal("seq_count", 32'(instr_count), 32'd1);

        applyStimulus(3'd0, 3, 3, 1'b0, -1);

        doReset(1, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(3'd2, -1, 0, 1'b0, -1);
        checkVal("wrap_count", 32'(instr_count), 32'd1);

        for (int k = 0; k < 80; k++) applyStimulus(3'($urandom), -1, 0, 1'b1, -1);

        applyStimulus(3'd4, -1, 0, 1'b0, 4);
        applyStimulus(3'd5, -1, 0, 1'b0, 3);
        applyStimulus(3'd4, -1, 0, 1'b0, -1);
        checkVal("recover_count", 32'(instr_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
